// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the PS/2 to ZX Spectrum keyboard bridge.
// Cursor-key mapping is enabled by defining KBD_CURSOR_EN.
package zx_kbd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_APPLY
    } kbd_state_t;

    typedef struct packed {
        logic       valid;
        logic       compound;
        logic [2:0] row;
        logic [2:0] col;
    } map_entry_t;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    localparam logic [2:0] C0 = 3'd0;
    localparam logic [2:0] C1 = 3'd1;
    localparam logic [2:0] C2 = 3'd2;
    localparam logic [2:0] C3 = 3'd3;
    localparam logic [2:0] C4 = 3'd4;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_DEL    = 8'h71;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    function automatic map_entry_t ent(
        input logic [2:0] r,
        input logic [2:0] c,
        input logic       comp
    );
        ent = '{valid: 1'b1, compound: comp, row: r, col: c};
    endfunction

endpackage

// File: rtl/zx_kbd_map.sv
// Combinational set-2 scancode to ZX matrix position lookup.
// Extended cursor keys are mapped only when KBD_CURSOR_EN is defined.
module zx_kbd_map
    import zx_kbd_pkg::*;
(
    input  logic       extended,
    input  logic [7:0] scancode,
    output map_entry_t entry
);

    always_comb begin
        entry = '0;
        if (!extended) begin
            unique case (scancode)
                8'h1A:   entry = ent(R0, C1, 1'b0);
                8'h22:   entry = ent(R0, C2, 1'b0);
                8'h21:   entry = ent(R0, C3, 1'b0);
                8'h2A:   entry = ent(R0, C4, 1'b0);
                8'h1C:   entry = ent(R1, C0, 1'b0);
                8'h1B:   entry = ent(R1, C1, 1'b0);
                8'h23:   entry = ent(R1, C2, 1'b0);
                8'h2B:   entry = ent(R1, C3, 1'b0);
                8'h34:   entry = ent(R1, C4, 1'b0);
                8'h15:   entry = ent(R2, C0, 1'b0);
                8'h1D:   entry = ent(R2, C1, 1'b0);
                8'h24:   entry = ent(R2, C2, 1'b0);
                8'h2D:   entry = ent(R2, C3, 1'b0);
                8'h2C:   entry = ent(R2, C4, 1'b0);
                8'h16:   entry = ent(R3, C0, 1'b0);
                8'h1E:   entry = ent(R3, C1, 1'b0);
                8'h26:   entry = ent(R3, C2, 1'b0);
                8'h25:   entry = ent(R3, C3, 1'b0);
                8'h2E:   entry = ent(R3, C4, 1'b0);
                8'h45:   entry = ent(R4, C0, 1'b0);
                8'h46:   entry = ent(R4, C1, 1'b0);
                8'h3E:   entry = ent(R4, C2, 1'b0);
                8'h3D:   entry = ent(R4, C3, 1'b0);
                8'h36:   entry = ent(R4, C4, 1'b0);
                8'h4D:   entry = ent(R5, C0, 1'b0);
                8'h44:   entry = ent(R5, C1, 1'b0);
                8'h43:   entry = ent(R5, C2, 1'b0);
                8'h3C:   entry = ent(R5, C3, 1'b0);
                8'h35:   entry = ent(R5, C4, 1'b0);
                8'h5A:   entry = ent(R6, C0, 1'b0);
                8'h4B:   entry = ent(R6, C1, 1'b0);
                8'h42:   entry = ent(R6, C2, 1'b0);
                8'h3B:   entry = ent(R6, C3, 1'b0);
                8'h33:   entry = ent(R6, C4, 1'b0);
                8'h29:   entry = ent(R7, C0, 1'b0);
                8'h49:   entry = ent(R7, C1, 1'b0);
                8'h3A:   entry = ent(R7, C2, 1'b0);
                8'h31:   entry = ent(R7, C3, 1'b0);
                8'h32:   entry = ent(R7, C4, 1'b0);
                SC_BKSP: entry = ent(R4, C0, 1'b1);
                SC_ESC:  entry = ent(R7, C0, 1'b1);
                default: entry = '0;
            endcase
        end
`ifdef KBD_CURSOR_EN
        else begin
            unique case (scancode)
                SC_LEFT:  entry = ent(R3, C4, 1'b1);
                SC_DOWN:  entry = ent(R4, C4, 1'b1);
                SC_UP:    entry = ent(R4, C3, 1'b1);
                SC_RIGHT: entry = ent(R4, C2, 1'b1);
                default:  entry = '0;
            endcase
        end
`endif
    end

endmodule

// File: rtl/zx_keyboard.sv
// PS/2 keyboard to ZX Spectrum 8x5 matrix bridge with Ctrl-Alt-Del reset.
// Define KBD_CURSOR_EN to map extended cursor keys onto SHIFT+5..8.
module zx_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int RST_PULSE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  addr_hi,
    output logic [4:0]  key_data,
    output logic        reset_req
);

    localparam int CW = $clog2(RST_PULSE) + 1;

    kbd_state_t      state;
    logic            pressed_q;
    logic            ext_q;
    logic [7:0]      code_q;
    map_entry_t      map_ent;
    map_entry_t      ent_q;
    logic [7:0][4:0] mat;
    logic            lshift;
    logic            rshift;
    logic            ctrl;
    logic            alt;
    logic [1:0]      comp_cnt;
    logic [CW-1:0]   rst_cnt;
    logic [7:0][4:0] view;
    logic [4:0]      held;

    logic strobe;
    logic is_ctrl;
    logic is_alt;
    logic is_lsh;
    logic is_rsh;
    logic is_cad;

    assign strobe  = ps2_key[10];
    assign is_ctrl = (code_q == SC_CTRL);
    assign is_alt  = (code_q == SC_ALT);
    assign is_lsh  = !ext_q && (code_q == SC_LSHIFT);
    assign is_rsh  = !ext_q && (code_q == SC_RSHIFT);
    assign is_cad  = ext_q && (code_q == SC_DEL) && pressed_q && ctrl && alt;

    zx_kbd_map u_map (
        .extended (ext_q),
        .scancode (code_q),
        .entry    (map_ent)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pressed_q <= 1'b0;
            ext_q     <= 1'b0;
            code_q    <= '0;
            ent_q     <= '0;
            mat       <= '0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            ctrl      <= 1'b0;
            alt       <= 1'b0;
            comp_cnt  <= '0;
            reset_req <= 1'b0;
            rst_cnt   <= '0;
        end else begin
            if (reset_req) begin
                if (rst_cnt == '0) reset_req <= 1'b0;
                else rst_cnt <= rst_cnt - 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (strobe) begin
                        pressed_q <= ps2_key[9];
                        ext_q     <= ps2_key[8];
                        code_q    <= ps2_key[7:0];
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    ent_q <= map_ent;
                    state <= S_APPLY;
                end
                S_APPLY: begin
                    state <= S_IDLE;
                    if (is_cad) begin
                        // Takes priority over the countdown above, restarting it.
                        mat       <= '0;
                        comp_cnt  <= '0;
                        lshift    <= 1'b0;
                        rshift    <= 1'b0;
                        reset_req <= 1'b1;
                        rst_cnt   <= CW'(RST_PULSE - 1);
                    end else if (is_ctrl) begin
                        ctrl <= pressed_q;
                    end else if (is_alt) begin
                        alt <= pressed_q;
                    end else if (is_lsh) begin
                        lshift <= pressed_q;
                    end else if (is_rsh) begin
                        rshift <= pressed_q;
                    end else if (ent_q.valid) begin
                        mat[ent_q.row][ent_q.col] <= pressed_q;
                        if (ent_q.compound) begin
                            if (pressed_q) begin
                                if (comp_cnt != 2'd3)
                                    comp_cnt <= comp_cnt + 2'd1;
                            end else if (comp_cnt != 2'd0) begin
                                comp_cnt <= comp_cnt - 2'd1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // SHIFT is never stored in the matrix; it is derived from its sources.
    always_comb begin
        view       = mat;
        view[0][0] = lshift | rshift | (comp_cnt != 2'd0);
        held       = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi[r]) held = held | view[r];
        end
        key_data = ~held;
    end

endmodule

// File: tb/tb_zx_keyboard.sv
// Directed self-checking bench for zx_keyboard.
// Cursor expectations follow KBD_CURSOR_EN when it is defined.
module tb_zx_keyboard;

    logic        clk;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [7:0]  addr_hi;
    logic [4:0]  key_data;
    logic        reset_req;

    int checks;
    int errors;
    int n;

    zx_keyboard #(.RST_PULSE(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .addr_hi   (addr_hi),
        .key_data  (key_data),
        .reset_req (reset_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic p, input logic e, input logic [7:0] c);
        ps2_key = {1'b1, p, e, c};
        tick();
        ps2_key = '0;
        repeat (2) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] a, input logic [4:0] exp);
        addr_hi = a;
        #1;
        checks++;
        assert (key_data === exp) else begin
            errors++;
            $error("FAIL %s: key_data=%h expected %h", tag, key_data, exp);
        end
        tick();
    endtask

    task automatic chk_rr(input string tag, input logic exp);
        checks++;
        assert (reset_req === exp) else begin
            errors++;
            $error("FAIL %s: reset_req=%b expected %b", tag, reset_req, exp);
        end
    endtask

    task automatic count_pulse(input string tag);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (reset_req) n++;
            tick();
        end
        checks++;
        assert (n == 16) else begin
            errors++;
            $error("FAIL %s: pulse cycles=%0d expected 16", tag, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        ps2_key = '0;
        addr_hi = 8'hFF;
        repeat (3) tick();
        chk("in_reset", 8'h00, 5'h1F);
        chk_rr("in_reset_rr", 1'b0);
        reset_n = 1'b1;
        tick();
        chk("after_reset", 8'h00, 5'h1F);

        // Plain key and latency
        send(1'b1, 1'b0, 8'h1C);
        chk("a_row1", 8'hFD, 5'h1E);
        chk("a_all", 8'h00, 5'h1E);
        chk("a_row0", 8'hFE, 5'h1F);
        send(1'b0, 1'b0, 8'h1C);
        chk("a_rel", 8'hFD, 5'h1F);

        // Backspace compound
        send(1'b1, 1'b0, 8'h66);
        chk("bs_sh", 8'hFE, 5'h1E);
        chk("bs_0", 8'hEF, 5'h1E);
        send(1'b0, 1'b0, 8'h66);
        chk("bs_rel_sh", 8'hFE, 5'h1F);
        chk("bs_rel_0", 8'hEF, 5'h1F);
        send(1'b0, 1'b0, 8'h66);
        chk("bs_rel2", 8'hFE, 5'h1F);
        send(1'b1, 1'b0, 8'h66);
        send(1'b0, 1'b0, 8'h66);
        chk("bs_floor", 8'hFE, 5'h1F);

        // L-Shift held across a compound key
        send(1'b1, 1'b0, 8'h12);
        chk("lsh", 8'hFE, 5'h1E);
        send(1'b1, 1'b0, 8'h66);
        chk("lsh_bs", 8'hFE, 5'h1E);
        send(1'b0, 1'b0, 8'h66);
        chk("lsh_bsrel", 8'hFE, 5'h1E);
        chk("lsh_bsrel0", 8'hEF, 5'h1F);
        send(1'b0, 1'b0, 8'h12);
        chk("lsh_rel", 8'hFE, 5'h1F);

        // Escape and R-Shift
        send(1'b1, 1'b0, 8'h76);
        chk("esc_sp", 8'h7F, 5'h1E);
        chk("esc_sh", 8'hFE, 5'h1E);
        send(1'b0, 1'b0, 8'h76);
        chk("esc_rel", 8'h7E, 5'h1F);
        send(1'b1, 1'b0, 8'h59);
        chk("rsh", 8'hFE, 5'h1E);
        send(1'b0, 1'b0, 8'h59);

        // Two keys, two rows selected
        send(1'b1, 1'b0, 8'h1A);
        send(1'b1, 1'b0, 8'h2E);
        chk("z5", 8'hF6, 5'h0D);
        chk("z_only", 8'hFE, 5'h1D);
        send(1'b0, 1'b0, 8'h1A);
        send(1'b0, 1'b0, 8'h2E);
        chk("z5_rel", 8'h00, 5'h1F);

        // Unmapped code
        send(1'b1, 1'b0, 8'h05);
        chk("unmapped", 8'h00, 5'h1F);

        // Ctrl-Alt-Del
        send(1'b1, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h14);
        send(1'b1, 1'b1, 8'h11);
        chk("ctrl_alt", 8'h00, 5'h1E);
        send(1'b1, 1'b1, 8'h71);
        chk_rr("cad_start", 1'b1);
        count_pulse("cad_pulse");
        chk("cad_clear", 8'h00, 5'h1F);
        chk_rr("cad_end", 1'b0);

        // Restart mid-pulse
        send(1'b1, 1'b1, 8'h71);
        repeat (4) tick();
        send(1'b1, 1'b1, 8'h71);
        count_pulse("cad_restart");
        send(1'b0, 1'b0, 8'h14);
        send(1'b0, 1'b1, 8'h11);
        send(1'b1, 1'b1, 8'h71);
        chk_rr("del_no_mods", 1'b0);

        // Extended cursor up
        send(1'b1, 1'b1, 8'h75);
`ifdef KBD_CURSOR_EN
        chk("up_7", 8'hEF, 5'h17);
        chk("up_sh", 8'hFE, 5'h1E);
`else
        chk("up_7", 8'hEF, 5'h1F);
        chk("up_sh", 8'hFE, 5'h1F);
        chk("up_all", 8'h00, 5'h1F);
`endif
        send(1'b0, 1'b1, 8'h75);
        chk("up_rel", 8'h00, 5'h1F);

        // Second strobe during LOOKUP is dropped
        ps2_key = {3'b110, 8'h1D};
        tick();
        ps2_key = {3'b110, 8'h24};
        tick();
        ps2_key = '0;
        tick();
        chk("dbl_strobe", 8'hFB, 5'h1D);
        send(1'b0, 1'b0, 8'h1D);
        chk("dbl_rel", 8'hFB, 5'h1F);

        // Reset during LOOKUP drops the pending press
        ps2_key = {3'b110, 8'h15};
        tick();
        ps2_key = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rst_lookup", 8'hFB, 5'h1F);
        chk_rr("rst_lookup_rr", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
